// File: rtl/dht11_pkg.sv
// Constants shared by the DHT11 responder and the host-side reader.
package dht11_pkg;

   localparam int ACK_LOW_US   = 80;
   localparam int ACK_HIGH_US  = 80;
   localparam int BIT_LOW_US   = 50;
   localparam int BIT0_HIGH_US = 27;
   localparam int BIT1_HIGH_US = 70;
   localparam int END_LOW_US   = 50;
   localparam int FRAME_BITS   = 40;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOST_LOW,
      ST_HOST_REL,
      ST_ACK_LOW,
      ST_ACK_HIGH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_END_LOW
   } dht11_state_t;

   function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c, input logic [7:0] d);
      return a + b + c + d;
   endfunction

endpackage

// File: rtl/dht11_responder_line_synchronizer.sv
// Two-flop synchronizer for the single-wire line; resets to the idle (released) level.
module line_synchronizer (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         dout <= 1'b1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects the host start pulse, answers with ACK and a 40-bit frame.
//   state     | meaning
//   IDLE      | line released, waiting for host low
//   HOST_LOW  | measuring host start pulse (up-count, saturating)
//   HOST_REL  | turnaround after host release
//   ACK_LOW   | responder ACK, line driven low
//   ACK_HIGH  | responder ACK, line released
//   BIT_LOW   | bit preamble, line driven low
//   BIT_HIGH  | bit value, released 27 us (0) or 70 us (1)
//   END_LOW   | final low, then release and count the frame
module dht11_responder
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int START_MIN_US  = 18000,
   parameter int TURNAROUND_US = 30
) (
   input  logic       clock,
   input  logic       reset,
   inout  wire        transmission_line,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_float,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_float,
   input  logic       corrupt_checksum,
   output logic       busy,
   output logic       done,
   output logic [7:0] frames_served
);

   localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
   localparam int START_CYC  = START_MIN_US * CYC_PER_US;
   localparam int TW         = $clog2(START_CYC + 1);

   function automatic logic [TW-1:0] phase_load(input int us);
      return TW'(us * CYC_PER_US - 1);
   endfunction

   localparam logic [TW-1:0] START_CNT      = TW'(START_CYC);
   localparam logic [TW-1:0] TURN_LOAD      = phase_load(TURNAROUND_US);
   localparam logic [TW-1:0] ACK_LOW_LOAD   = phase_load(ACK_LOW_US);
   localparam logic [TW-1:0] ACK_HIGH_LOAD  = phase_load(ACK_HIGH_US);
   localparam logic [TW-1:0] BIT_LOW_LOAD   = phase_load(BIT_LOW_US);
   localparam logic [TW-1:0] BIT0_HIGH_LOAD = phase_load(BIT0_HIGH_US);
   localparam logic [TW-1:0] BIT1_HIGH_LOAD = phase_load(BIT1_HIGH_US);
   localparam logic [TW-1:0] END_LOW_LOAD   = phase_load(END_LOW_US);

   dht11_state_t    state, state_next;
   logic [TW-1:0]   timer, timer_next;
   logic [5:0]      bit_idx, bit_idx_next;
   logic [FRAME_BITS-1:0] frame, frame_next;
   logic            drive_low, drive_low_next;
   logic            done_next;
   logic            line_s;
   logic            timer_zero;
   logic [7:0]      checksum;

   line_synchronizer u_sync (
      .clock (clock),
      .reset (reset),
      .din   (transmission_line),
      .dout  (line_s)
   );

   assign transmission_line = drive_low ? 1'b0 : 1'bz;

   assign timer_zero = (timer == '0);
   assign checksum   = dht11_checksum(hum_int, hum_float, temp_int, temp_float)
                       ^ {7'd0, corrupt_checksum};
   assign busy       = state inside {ST_ACK_LOW, ST_ACK_HIGH, ST_BIT_LOW, ST_BIT_HIGH, ST_END_LOW};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         timer     <= '0;
         bit_idx   <= '0;
         frame     <= '0;
         drive_low <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         timer     <= timer_next;
         bit_idx   <= bit_idx_next;
         frame     <= frame_next;
         drive_low <= drive_low_next;
         done      <= done_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         frames_served <= 8'd0;
      else if (done_next)
         frames_served <= frames_served + 8'd1;
   end

   always_comb begin
      state_next     = state;
      timer_next     = timer;
      bit_idx_next   = bit_idx;
      frame_next     = frame;
      drive_low_next = drive_low;
      done_next      = 1'b0;

      case (state)
         ST_IDLE: begin
            timer_next     = '0;
            drive_low_next = 1'b0;
            if (!line_s)
               state_next = ST_HOST_LOW;
         end

         ST_HOST_LOW: begin
            if (line_s) begin
               if (timer >= START_CNT) begin
                  state_next = ST_HOST_REL;
                  timer_next = TURN_LOAD;
               end else begin
                  state_next = ST_IDLE;
                  timer_next = '0;
               end
            end else if (timer < START_CNT) begin
               timer_next = timer + 1'b1;
            end
         end

         ST_HOST_REL: begin
            if (!line_s) begin
               state_next = ST_HOST_LOW;
               timer_next = '0;
            end else if (timer_zero) begin
               // Inputs are frozen here so later register changes cannot tear the frame.
               state_next     = ST_ACK_LOW;
               timer_next     = ACK_LOW_LOAD;
               drive_low_next = 1'b1;
               frame_next     = {hum_int, hum_float, temp_int, temp_float, checksum};
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         ST_ACK_LOW: begin
            if (timer_zero) begin
               state_next     = ST_ACK_HIGH;
               timer_next     = ACK_HIGH_LOAD;
               drive_low_next = 1'b0;
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         ST_ACK_HIGH: begin
            if (timer_zero) begin
               state_next     = ST_BIT_LOW;
               timer_next     = BIT_LOW_LOAD;
               drive_low_next = 1'b1;
               bit_idx_next   = 6'(FRAME_BITS - 1);
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         ST_BIT_LOW: begin
            if (timer_zero) begin
               state_next     = ST_BIT_HIGH;
               timer_next     = frame[bit_idx] ? BIT1_HIGH_LOAD : BIT0_HIGH_LOAD;
               drive_low_next = 1'b0;
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         ST_BIT_HIGH: begin
            if (timer_zero) begin
               drive_low_next = 1'b1;
               if (bit_idx != 6'd0) begin
                  state_next   = ST_BIT_LOW;
                  timer_next   = BIT_LOW_LOAD;
                  bit_idx_next = bit_idx - 6'd1;
               end else begin
                  state_next = ST_END_LOW;
                  timer_next = END_LOW_LOAD;
               end
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         ST_END_LOW: begin
            if (timer_zero) begin
               state_next     = ST_IDLE;
               timer_next     = '0;
               drive_low_next = 1'b0;
               done_next      = 1'b1;
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         default: begin
            state_next     = ST_IDLE;
            timer_next     = '0;
            drive_low_next = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Single-wire DHT11 responder (sensor emulator) on `transmission_line`. It detects the host start pulse and answers with the standard ACK and a 40-bit frame built from register inputs. It is used for FPGA loopback and bench verification of the host-side DHT11 reader, so the request/response path can be exercised without a physical sensor.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: clock frequency. `CYC_PER_US = CLK_FREQ_HZ / 1_000_000` must be an integer.
- `START_MIN_US`, 18000: minimum host low time accepted as a start request.
- `TURNAROUND_US`, 30: delay from the detected host release to the responder's ACK low.
- `clock` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `transmission_line` inout 1: open-drain line. The block drives 0 or Z, never 1.
- `hum_int`, `hum_float`, `temp_int`, `temp_float` in 8 each: measurement values to serve.
- `corrupt_checksum` in 1: error injection. When 1, the transmitted checksum is XORed with 8'h01.
- `busy` out 1: high from ACK start to the end of the final low.
- `done` out 1: one-cycle pulse when a frame completes.
- `frames_served` out 8: count of completed frames, wraps 255→0.

## Operation
- The line is sampled through a 2-FF synchronizer, giving `line_s`. All detection uses `line_s`.
- `drive_low` is a registered output; `transmission_line = drive_low ? 1'b0 : 1'bz`.
- Timer: a single down-counter sized `$clog2(START_MIN_US*CYC_PER_US+1)`. A phase of N µs loads `N*CYC_PER_US-1` and ends when the count reaches 0.
- States:
  - **IDLE**: `drive_low=0`. Go to HOST_LOW when `line_s` is 0. Counter clears.
  - **HOST_LOW**: count up while `line_s` is 0; the counter saturates at `START_MIN_US*CYC_PER_US`.
    - If `line_s` goes to 1 and the count has reached the minimum, go to HOST_REL.
    - If `line_s` goes to 1 before the minimum, return to IDLE; this is a glitch or short pulse, with no response and no count.
  - **HOST_REL**: wait `TURNAROUND_US`.
    - If `line_s` drops to 0 during this wait, return to HOST_LOW with the count reset.
    - At the end of the wait, latch the frame and go to ACK_LOW.
  - **ACK_LOW**: 80 µs with the line driven low, then ACK_HIGH.
  - **ACK_HIGH**: 80 µs released, then BIT_LOW with bit index 39.
  - **BIT_LOW**: 50 µs low, then BIT_HIGH.
  - **BIT_HIGH**: released for 27 µs if the current bit is 0, or 70 µs if it is 1.
    - If index > 0, decrement the index and go to BIT_LOW.
    - Otherwise go to END_LOW.
  - **END_LOW**: 50 µs low, then release, pulse `done`, increment `frames_served`, and go to IDLE.
- Frame layout, MSB first: `{hum_int, hum_float, temp_int, temp_float, checksum}`.
  - `checksum = (hum_int + hum_float + temp_int + temp_float) mod 256`, XORed with 8'h01 if `corrupt_checksum` is set.
  - All inputs are captured at the HOST_REL→ACK_LOW transition. Input changes after capture do not affect the frame in flight.
- During the response states (ACK_LOW through END_LOW), host activity on the line is ignored.
- `busy` is 1 in ACK_LOW through END_LOW inclusive.

## Timing
- Reset values: `drive_low` 0 (line Z), `busy` 0, `done` 0, `frames_served` 0, state IDLE, synchronizer flops 1.
- Reset asserted mid-frame releases the line immediately (asynchronous) and aborts the frame. No `done` pulse and no count increment.
- Edge detection latency is 2 cycles from the pin to `line_s`.
- The ACK falling edge appears `TURNAROUND_US*CYC_PER_US + 3` cycles (±1) after the host release at the pin.
- Each phase lasts exactly `N*CYC_PER_US` cycles, ±1 cycle at phase boundaries.
- `done` is high for exactly 1 cycle, coincident with `drive_low` going 0 after END_LOW and with `busy` falling.
- `frames_served` updates in the same cycle as `done`.

## Structure
- Shared package `dht11_pkg`:
  - phase durations in µs (80, 80, 50, 27, 70, 50);
  - state enum localparams;
  - frame width 40.
  - The host-side reader uses the same constants.
- Sub-module `line_synchronizer`: 2-FF synchronizer with an asynchronous reset value of 1. It is reusable by the host reader.

## Test plan
Benches use `CLK_FREQ_HZ=1_000_000` and `START_MIN_US=200`.
- Reset: with `reset` held high, the line is Z, `busy`=0, `done`=0, `frames_served`=0. The line stays Z with no host activity.
- Nominal frame:
  - Stimulus: host drives low 250 µs, then releases; inputs 0x35/0x00/0x18/0x00.
  - Required: line low 80 µs starting 30 µs after release, then high 80 µs.
  - Required: decoded bits give 0x35,0x00,0x18,0x00,0x4D.
  - Required: `done` pulses once and `frames_served`=1.
- Short start: host low 150 µs → no drive, `busy` stays 0, `frames_served` unchanged.
- Checksum handling:
  - `corrupt_checksum=1` with the nominal data → checksum byte 0x4C.
  - Inputs 0xFF,0xFF,0x01,0x01 → checksum 0x00 (mod-256 wrap).
- Input change mid-frame: change `temp_int` to 0x20 during bit 20 → the transmitted frame still carries 0x18.
- Reset mid-frame:
  - Assert `reset` during BIT_HIGH of bit 10 → line is Z immediately, no `done`, and a following valid start is served normally.
  - Preload 255 frames, then serve one more → `frames_served` wraps to 0.
